// File: rtl/fwd_stall_ctrl_pkg.sv
// fwd_stall_ctrl_pkg: shared encodings and match helpers for the hazard controller
package fwd_stall_ctrl_pkg;
  localparam int TNEW_W = 2;
  typedef logic [TNEW_W-1:0] tnew_t;
  localparam logic [1:0] FW_NONE = 2'b00;
  localparam logic [1:0] FW_W = 2'b01;
  localparam logic [1:0] FW_M = 2'b10;
  localparam logic [1:0] FW_E = 2'b10;
  localparam logic [1:0] FW_MST = 2'b01;
  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV = 2'b10;
  localparam logic [1:0] TUSE_NEVER = 2'd3;
  function automatic logic hazard(input logic [4:0] a, input logic [1:0] tuse,
                                  input logic [4:0] a3, input tnew_t tnew);
    return a != 5'd0 && a == a3 && tuse < tnew;
  endfunction
  function automatic logic fw_ready(input logic [4:0] a, input logic [4:0] a3, input tnew_t tnew);
    return a != 5'd0 && a == a3 && tnew == '0;
  endfunction
endpackage

// File: rtl/fwd_stall_ctrl_md_busy_cnt.sv
// md_busy_cnt: MDU start decode and busy countdown
module md_busy_cnt
  import fwd_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] md_op,
  output logic       md_start,
  output logic       md_busy
);
  logic [3:0] cnt;
  always_comb md_start = md_op == MD_MULT || md_op == MD_DIV;
  always_comb md_busy = md_start || cnt != 4'd0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= 4'd0;
    else if (md_start) cnt <= md_op == MD_MULT ? 4'(MULT_CYC) : 4'(DIV_CYC);
    else if (cnt != 4'd0) cnt <= cnt - 4'd1;
endmodule

// File: rtl/fwd_stall_ctrl.sv
// fwd_stall_ctrl: forwarding selects, load-use stall and MDU interlock for the 5-stage pipeline
module fwd_stall_ctrl
  import fwd_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic [4:0] D_A3,
  input  logic [1:0] D_Tnew,
  input  logic [1:0] D_md_op,
  input  logic       D_md_use,
  output logic       stall,
  output logic [1:0] D_FW_rs_sel,
  output logic [1:0] D_FW_rt_sel,
  output logic [1:0] E_FW_rs_sel,
  output logic [1:0] E_FW_rt_sel,
  output logic       M_FW_rt_sel,
  output logic       md_start,
  output logic       md_busy
);
  logic [4:0] e_rs, e_rt, e_a3, m_rt, m_a3, w_a3;
  tnew_t e_tnew, m_tnew;
  logic [1:0] e_md_op;
  md_busy_cnt #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) u_md (
    .clk(clk), .reset(reset), .md_op(e_md_op), .md_start(md_start), .md_busy(md_busy)
  );
  always_comb stall = hazard(D_rs, D_Tuse_rs, e_a3, e_tnew) || hazard(D_rs, D_Tuse_rs, m_a3, m_tnew)
                   || hazard(D_rt, D_Tuse_rt, e_a3, e_tnew) || hazard(D_rt, D_Tuse_rt, m_a3, m_tnew)
                   || (D_md_use && md_busy);
  always_comb D_FW_rs_sel = fw_ready(D_rs, e_a3, e_tnew) ? FW_E : fw_ready(D_rs, m_a3, m_tnew) ? FW_MST : FW_NONE;
  always_comb D_FW_rt_sel = fw_ready(D_rt, e_a3, e_tnew) ? FW_E : fw_ready(D_rt, m_a3, m_tnew) ? FW_MST : FW_NONE;
  // W results are always ready, so any W match forwards
  always_comb E_FW_rs_sel = fw_ready(e_rs, m_a3, m_tnew) ? FW_M : fw_ready(e_rs, w_a3, '0) ? FW_W : FW_NONE;
  always_comb E_FW_rt_sel = fw_ready(e_rt, m_a3, m_tnew) ? FW_M : fw_ready(e_rt, w_a3, '0) ? FW_W : FW_NONE;
  always_comb M_FW_rt_sel = fw_ready(m_rt, w_a3, '0);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      e_rs <= '0;
      e_rt <= '0;
      e_a3 <= '0;
      e_tnew <= '0;
      e_md_op <= '0;
      m_rt <= '0;
      m_a3 <= '0;
      m_tnew <= '0;
      w_a3 <= '0;
    end else begin
      w_a3 <= m_a3;
      m_rt <= e_rt;
      m_a3 <= e_a3;
      m_tnew <= e_tnew == '0 ? '0 : e_tnew - tnew_t'(1);
      e_rs <= stall ? '0 : D_rs;
      e_rt <= stall ? '0 : D_rt;
      e_a3 <= stall ? '0 : D_A3;
      e_tnew <= stall ? '0 : D_Tnew;
      e_md_op <= stall ? '0 : D_md_op;
    end
endmodule
